// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/response bundle for the iterative multiply/divide unit.
//
// Signals (master drives the request side, slave drives the response side):
//   Start      request to begin an operation
//   Kill       synchronous abort of the in-flight operation
//   Operation  operation select, sampled when a request is accepted
//   SrcA       multiplicand / dividend
//   SrcB       multiplier / divisor
//   Busy       high while an operation is iterating
//   Done       one-cycle pulse marking Result valid
//   Result     operation result, held until the next Done or reset
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
);
  logic                  Start;
  logic                  Kill;
  logic [OP_WIDTH-1:0]   Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] Result;

  modport master (
    output Start, Kill, Operation, SrcA, SrcB,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, Kill, Operation, SrcA, SrcB,
    output Busy, Done, Result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative integer multiply / divide unit.
//
// Ports:
//   clk    single clock, all state changes on its rising edge
//   reset  asynchronous, active-high reset
//   bus    muldiv_unit_if slave modport (Start/Kill/Operation/SrcA/SrcB in,
//          Busy/Done/Result out)
//
// Operations (Operation[2:0]): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
// 100 DIV, 101 DIVU, 110 REM, 111 REMU.  The core works on operand
// magnitudes for DATA_WIDTH cycles (one shift-add or restoring
// subtract-shift step per cycle) and fixes the sign at the end.  Divide by
// zero and signed DIV/REM overflow bypass the iteration entirely.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [OP_WIDTH-1:0] op;
  logic                neg;
  logic [W-1:0]        hi;
  logic [W-1:0]        lo;
  logic [W-1:0]        b;
  logic [W-1:0]        result;
  logic                done;

  // Request-side decode: which operands are signed, their magnitudes, the
  // sign to apply to the final answer, and the two bypass cases.
  logic [2:0]   new_op;
  logic         a_signed, b_signed, neg_a, neg_b, neg_flag;
  logic [W-1:0] mag_a, mag_b;
  logic         div_zero, div_ovf;

  always_comb begin
    new_op   = bus.Operation[2:0];
    a_signed = (new_op == 3'b001) || (new_op == 3'b010) ||
               (new_op == 3'b100) || (new_op == 3'b110);
    b_signed = (new_op == 3'b001) || (new_op == 3'b100) || (new_op == 3'b110);
    neg_a    = a_signed & bus.SrcA[W-1];
    neg_b    = b_signed & bus.SrcB[W-1];
    mag_a    = neg_a ? (~bus.SrcA + 1'b1) : bus.SrcA;
    mag_b    = neg_b ? (~bus.SrcB + 1'b1) : bus.SrcB;
    // Remainder follows the dividend; product and quotient follow the XOR.
    neg_flag = (new_op[2] && new_op[1]) ? neg_a : (neg_a ^ neg_b);
    div_zero = new_op[2] && (bus.SrcB == '0);
    div_ovf  = new_op[2] && !new_op[0] && (bus.SrcA == MOST_NEG) && (bus.SrcB == '1);
  end

  // One iteration step.  Multiply: {hi,lo} is a right-shifting product
  // register with the multiplier consumed from lo[0].  Divide: hi is the
  // partial remainder and lo shifts the dividend out while the quotient
  // bits shift in; hi < b always holds, so a successful subtract fits W bits.
  logic [W:0]   mul_sum;
  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         sub_ok;
  logic [W-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    shifted = {hi, lo[W-1]};
    sub_ok  = (shifted >= {1'b0, b});
    diff    = W'(shifted - {1'b0, b});
    if (!op[2]) begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], lo[W-1:1]};
    end else if (sub_ok) begin
      step_hi = diff;
      step_lo = {lo[W-2:0], 1'b1};
    end else begin
      step_hi = shifted[W-1:0];
      step_lo = {lo[W-2:0], 1'b0};
    end
  end

  // Final answer from the last step's values, with the sign restored.
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   quo_s, rem_s, final_res;

  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = neg ? (~prod + 1'b1) : prod;
    quo_s  = neg ? (~step_lo + 1'b1) : step_lo;
    rem_s  = neg ? (~step_hi + 1'b1) : step_hi;
    case (op[2:0])
      3'b000:                 final_res = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*W-1:W];
      3'b100, 3'b101:         final_res = quo_s;
      default:                final_res = rem_s;
    endcase
  end

  // Control FSM and datapath registers.  Kill wins over everything and
  // leaves Result untouched.  A request is taken in IDLE or FIN; in FIN
  // this gives back-to-back operation while Done still pulses for the
  // finishing one.  Result only ever receives finished values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      b      <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.Kill) begin
        state <= IDLE;
      end else begin
        case (state)
          CALC: begin
            hi  <= step_hi;
            lo  <= step_lo;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(W - 1)) begin
              state  <= FIN;
              done   <= 1'b1;
              result <= final_res;
            end
          end
          default: begin
            if (bus.Start) begin
              op  <= bus.Operation;
              neg <= neg_flag;
              cnt <= '0;
              b   <= mag_b;
              if (div_zero) begin
                state  <= FIN;
                done   <= 1'b1;
                result <= new_op[1] ? bus.SrcA : '1;
              end else if (div_ovf) begin
                state  <= FIN;
                done   <= 1'b1;
                result <= new_op[1] ? '0 : MOST_NEG;
              end else begin
                state <= CALC;
                hi    <= '0;
                lo    <= mag_a;
              end
            end else begin
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign bus.Busy   = (state == CALC);
  assign bus.Done   = done;
  assign bus.Result = result;
endmodule
